// File: rtl/intadd_wb_if.sv
// Register-file writeback beat bus between intadd_wb and the regfile.
// Master drives the beat; slave returns ready.
interface intadd_wb_if #(
  parameter int DW = 128
);
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;
  logic          idx;
  logic          last;
  logic [4:0]    smc_id;

  modport master (
    output valid, data, idx, last, smc_id,
    input  ready
  );

  modport slave (
    input  valid, data, idx, last, smc_id,
    output ready
  );
endinterface

// File: rtl/intadd_wb.sv
// Integer-add writeback stage: buffers intadd results in a small FIFO
// and drains them to the register file as one or two beats per op.
module intadd_wb #(
  parameter int DEPTH = 4,
  parameter int DW    = 128
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [DW-1:0]  i_dst_reg0,
  input  logic [DW-1:0]  i_dst_reg1,
  input  logic [DW-1:0]  i_st,
  input  logic [11:0]    i_cru_intadd,
  input  logic [4:0]     i_smc_id,
  intadd_wb_if.master    wb,
  output logic           o_st_valid,
  output logic [DW-1:0]  o_st_data,
  output logic           o_full,
  output logic           o_illegal,
  output logic           o_ovf_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULLC = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic [DW-1:0] st;
    logic          m32;
    logic          upd;
    logic [4:0]    id;
  } ent_t;

  typedef enum logic [1:0] {
    IDLE,
    B0,
    B1
  } state_t;

  ent_t          mem [DEPTH];
  ent_t          head;
  state_t        state, state_n;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, cnt_n;
  logic [5:0]    prec;
  logic          req, m32, ill;
  logic          hs, last, pop, push;
  logic          unused;

  assign unused = ^i_cru_intadd[4:1];
  assign prec   = i_cru_intadd[10:5];
  assign head   = mem[rd_ptr];

  always_comb begin
    req = 1'b0;
    m32 = 1'b0;
    ill = 1'b0;
    if (i_cru_intadd[11]) begin
      unique case (1'b1)
        (prec == 6'd0): req = 1'b1;
        (prec[5:2] == 4'b1111): begin
          req = 1'b1;
          m32 = 1'b1;
        end
        default: ill = 1'b1;
      endcase
    end
  end

  // Full FIFO still accepts when the head retires the same edge
  assign hs    = wb.valid & wb.ready;
  assign last  = (state == B1) | ((state == B0) & head.m32);
  assign pop   = hs & last;
  assign push  = req & ((count != FULLC) | pop);
  assign cnt_n = count + {{AW{1'b0}}, push}
                       - {{AW{1'b0}}, pop};

  always_comb begin
    state_n   = state;
    wb.valid  = 1'b0;
    wb.data   = '0;
    wb.idx    = 1'b0;
    wb.last   = 1'b0;
    wb.smc_id = '0;
    o_full    = (count == FULLC);
    unique case (state)
      IDLE: if (push) state_n = B0;
      B0: begin
        wb.valid  = 1'b1;
        wb.data   = head.d0;
        wb.last   = head.m32;
        wb.smc_id = head.id;
        if (hs) begin
          if (!head.m32) state_n = B1;
          else state_n = (cnt_n != '0) ? B0 : IDLE;
        end
      end
      B1: begin
        wb.valid  = 1'b1;
        wb.data   = head.d1;
        wb.idx    = 1'b1;
        wb.last   = 1'b1;
        wb.smc_id = head.id;
        if (hs) state_n = (cnt_n != '0) ? B0 : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{d0: i_dst_reg0, d1: i_dst_reg1,
                       st: i_st, m32: m32,
                       upd: i_cru_intadd[0], id: i_smc_id};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_st_valid <= 1'b0;
      o_st_data  <= '0;
      o_illegal  <= 1'b0;
      o_ovf_err  <= 1'b0;
    end else begin
      state      <= state_n;
      count      <= cnt_n;
      o_illegal  <= ill;
      o_ovf_err  <= o_ovf_err | (req & ~push);
      o_st_valid <= pop & head.upd;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (pop & head.upd) o_st_data <= head.st;
    end
  end

endmodule

// File: tb/tb_intadd_wb.sv
// Directed bench for intadd_wb: reset, both modes, FIFO full/overflow,
// illegal precision and a back-to-back drain against a beat scoreboard.
module tb_intadd_wb;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] dst0, dst1, st;
  logic [11:0]  cru;
  logic [4:0]   smc_id;
  logic         st_valid, full, illegal, ovf;
  logic [127:0] st_data;
  int           n_cmp = 0;
  int           n_err = 0;

  intadd_wb_if #(.DW(128)) wb ();

  intadd_wb #(.DEPTH(4), .DW(128)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_dst_reg0   (dst0),
    .i_dst_reg1   (dst1),
    .i_st         (st),
    .i_cru_intadd (cru),
    .i_smc_id     (smc_id),
    .wb           (wb),
    .o_st_valid   (st_valid),
    .o_st_data    (st_data),
    .o_full       (full),
    .o_illegal    (illegal),
    .o_ovf_err    (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] d;
    logic         idx;
    logic         last;
    logic [4:0]   id;
  } beat_t;

  function automatic logic [11:0] mk(input bit is32, input bit upd);
    return {1'b1, is32 ? 6'b111100 : 6'b000000, 4'b0, upd};
  endfunction

  task automatic put_op(input logic [127:0] a, input logic [127:0] b,
                        input logic [127:0] s, input logic [11:0] c,
                        input logic [4:0] id);
    dst0 = a; dst1 = b; st = s; cru = c; smc_id = id;
  endtask

  task automatic no_op();
    cru = '0; dst0 = '0; dst1 = '0; st = '0; smc_id = '0;
  endtask

  task automatic test_reset_init();
    rst_n = 1'b0; wb.ready = 1'b0; no_op();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({wb.valid, wb.idx, wb.last, wb.smc_id, full, illegal,
         ovf, st_valid} !== '0 || st_data !== '0 || wb.data !== '0) begin
      n_err++;
      $display("FAIL init_reset: valid=%b full=%b ovf=%b st_data=%h, all 0 required",
               wb.valid, full, ovf, st_data);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_mode32();
    wb.ready = 1'b1;
    @(negedge clk);
    put_op(128'h1234, 128'h5555, 128'hBEEF, mk(1, 1), 5'd3);
    @(negedge clk);
    no_op();
    n_cmp++;
    if ({wb.valid, wb.idx, wb.last, wb.smc_id, st_valid} !== {3'b101, 5'd3, 1'b0}
        || wb.data !== 128'h1234) begin
      n_err++;
      $display("FAIL m32_beat: v/i/l/id/stv=%b%b%b/%0d/%b data=%h, need 101/3/0 1234",
               wb.valid, wb.idx, wb.last, wb.smc_id, st_valid, wb.data);
    end
    @(negedge clk);
    n_cmp++;
    if ({wb.valid, st_valid} !== 2'b01 || st_data !== 128'hBEEF) begin
      n_err++;
      $display("FAIL m32_st: valid=%b st_valid=%b st_data=%h, need 0 1 beef",
               wb.valid, st_valid, st_data);
    end
    @(negedge clk);
    n_cmp++;
    if (st_valid !== 1'b0 || st_data !== 128'hBEEF) begin
      n_err++;
      $display("FAIL m32_st_hold: st_valid=%b st_data=%h, need 0 beef",
               st_valid, st_data);
    end
  endtask

  task automatic test_mode8();
    wb.ready = 1'b0;
    put_op(128'hA, 128'hB, 128'h77, mk(0, 0), 5'd5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      no_op();
      n_cmp++;
      if ({wb.valid, wb.idx, wb.last, wb.smc_id} !== {3'b100, 5'd5}
          || wb.data !== 128'hA) begin
        n_err++;
        $display("FAIL m8_beat0_hold%0d: v/i/l/id=%b%b%b/%0d data=%h, need 100/5 a",
                 i, wb.valid, wb.idx, wb.last, wb.smc_id, wb.data);
      end
    end
    wb.ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({wb.valid, wb.idx, wb.last, wb.smc_id} !== {3'b111, 5'd5}
        || wb.data !== 128'hB) begin
      n_err++;
      $display("FAIL m8_beat1: v/i/l/id=%b%b%b/%0d data=%h, need 111/5 b",
               wb.valid, wb.idx, wb.last, wb.smc_id, wb.data);
    end
    @(negedge clk);
    n_cmp++;
    if ({wb.valid, st_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL m8_no_st: valid=%b st_valid=%b, need 0 0",
               wb.valid, st_valid);
    end
    wb.ready = 1'b0;
  endtask

  task automatic test_full();
    logic [4:0] ids [3];
    ids = '{5'd12, 5'd13, 5'd15};
    wb.ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      put_op(128'h100 + 128'(k), '0, '0, mk(1, 0), 5'(10 + k));
    end
    @(negedge clk);
    no_op();
    n_cmp++;
    if ({full, ovf} !== 2'b10) begin
      n_err++;
      $display("FAIL full_set: full=%b ovf=%b, need 1 0", full, ovf);
    end
    put_op(128'h1EE, '0, '0, mk(1, 0), 5'd14);
    @(negedge clk);
    no_op();
    n_cmp++;
    if ({full, ovf} !== 2'b11) begin
      n_err++;
      $display("FAIL ovf_set: full=%b ovf=%b, need 1 1", full, ovf);
    end
    @(negedge clk);
    n_cmp++;
    if ({ovf, wb.smc_id} !== {1'b1, 5'd10}) begin
      n_err++;
      $display("FAIL ovf_sticky: ovf=%b head_id=%0d, need 1 10", ovf, wb.smc_id);
    end
    wb.ready = 1'b1;
    put_op(128'h1FF, '0, '0, mk(1, 0), 5'd15);
    @(negedge clk);
    no_op();
    n_cmp++;
    if ({full, illegal, wb.smc_id} !== {2'b10, 5'd11} || wb.data !== 128'h101) begin
      n_err++;
      $display("FAIL push_pop_full: full=%b ill=%b id=%0d data=%h, need 1 0 11 101",
               full, illegal, wb.smc_id, wb.data);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({wb.valid, wb.smc_id} !== {1'b1, ids[k]}) begin
        n_err++;
        $display("FAIL full_drain%0d: valid=%b id=%0d, need 1 %0d",
                 k, wb.valid, wb.smc_id, ids[k]);
      end
    end
    n_cmp++;
    if (wb.data !== 128'h1FF) begin
      n_err++;
      $display("FAIL full_last_data: data=%h, need 1ff", wb.data);
    end
    @(negedge clk);
    n_cmp++;
    if ({wb.valid, full} !== 2'b00) begin
      n_err++;
      $display("FAIL full_empty: valid=%b full=%b, need 0 0", wb.valid, full);
    end
    wb.ready = 1'b0;
  endtask

  task automatic test_reset();
    wb.ready = 1'b0;
    @(negedge clk);
    put_op(128'h21, 128'h22, 128'h23, mk(0, 1), 5'd7);
    @(negedge clk);
    put_op(128'h31, 128'h32, 128'h33, mk(0, 1), 5'd8);
    @(negedge clk);
    no_op();
    n_cmp++;
    if (wb.valid !== 1'b1) begin
      n_err++;
      $display("FAIL rst_pre: valid=%b, need 1", wb.valid);
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({wb.valid, wb.idx, wb.last, wb.smc_id, full, illegal,
         ovf, st_valid} !== '0 || st_data !== '0 || wb.data !== '0) begin
      n_err++;
      $display("FAIL mid_reset: valid=%b id=%0d ovf=%b st_data=%h data=%h, all 0 required",
               wb.valid, wb.smc_id, ovf, st_data, wb.data);
    end
    rst_n = 1'b1;
    wb.ready = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({wb.valid, st_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL post_reset: valid=%b st_valid=%b, need 0 0", wb.valid, st_valid);
    end
  endtask

  task automatic test_illegal();
    wb.ready = 1'b1;
    @(negedge clk);
    put_op(128'h99, '0, '0, {1'b1, 6'b011100, 5'b0}, 5'd9);
    @(negedge clk);
    no_op();
    n_cmp++;
    if ({illegal, wb.valid, full} !== 3'b100) begin
      n_err++;
      $display("FAIL illegal_pulse: ill=%b valid=%b full=%b, need 1 0 0",
               illegal, wb.valid, full);
    end
    @(negedge clk);
    n_cmp++;
    if ({illegal, wb.valid, ovf} !== 3'b000) begin
      n_err++;
      $display("FAIL illegal_clear: ill=%b valid=%b ovf=%b, need 0 0 0",
               illegal, wb.valid, ovf);
    end
  endtask

  task automatic test_back_to_back();
    beat_t        exp_q [$];
    logic [127:0] st_q [$];
    bit           m8 [6];
    int           pushed = 0;
    int           cyc = 0;
    m8 = '{1, 0, 0, 1, 0, 1};
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back('{128'h1000 + 128'(i), 1'b0, !m8[i], 5'(20 + i)});
      if (m8[i]) exp_q.push_back('{128'h2000 + 128'(i), 1'b1, 1'b1, 5'(20 + i)});
      if (i % 2 == 1) st_q.push_back(128'h3000 + 128'(i));
    end
    while ((pushed < 6 || exp_q.size() != 0 || st_q.size() != 0) && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (st_valid) begin
        n_cmp++;
        if (st_q.size() == 0) begin
          n_err++;
          $display("FAIL b2b_st_extra: st_data=%h, no st pulse expected", st_data);
        end else begin
          if (st_data !== st_q[0]) begin
            n_err++;
            $display("FAIL b2b_st: st_data=%h, need %h", st_data, st_q[0]);
          end
          void'(st_q.pop_front());
        end
      end
      wb.ready = ($urandom_range(0, 2) != 0);
      if (wb.valid && wb.ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL b2b_beat_extra: id=%0d data=%h, no beat expected",
                   wb.smc_id, wb.data);
        end else begin
          if (wb.data !== exp_q[0].d || wb.idx !== exp_q[0].idx ||
              wb.last !== exp_q[0].last || wb.smc_id !== exp_q[0].id) begin
            n_err++;
            $display("FAIL b2b_beat: data=%h i/l=%b%b id=%0d, need %h %b%b %0d",
                     wb.data, wb.idx, wb.last, wb.smc_id, exp_q[0].d,
                     exp_q[0].idx, exp_q[0].last, exp_q[0].id);
          end
          void'(exp_q.pop_front());
        end
      end
      if (pushed < 6 && !full) begin
        put_op(128'h1000 + 128'(pushed), 128'h2000 + 128'(pushed),
               128'h3000 + 128'(pushed), mk(!m8[pushed], pushed % 2 == 1),
               5'(20 + pushed));
        pushed++;
      end else begin
        no_op();
      end
    end
    n_cmp++;
    if (cyc >= 300 || ovf !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_done: cycles=%0d beats_left=%0d st_left=%0d ovf=%b, need <300 0 0 0",
               cyc, exp_q.size(), st_q.size(), ovf);
    end
    wb.ready = 1'b0;
  endtask

  initial begin
    test_reset_init();
    test_mode32();
    test_mode8();
    test_full();
    test_reset();
    test_illegal();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
